// File: rtl/rr_mux_arbiter.sv
// Four-way round-robin arbiter with a hold limit, driving a shared 1-bit mux.
// Grant, select and busy are registered; the mux output is combinational.
module rr_mux_arbiter #(
    parameter int HOLD_MAX = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    input  logic       a,
    input  logic       b,
    input  logic       c,
    input  logic       d,
    output logic [3:0] gnt,
    output logic [1:0] sel,
    output logic       busy,
    output logic       y
);

    typedef enum logic {IDLE, BUSY} state_t;

    localparam logic [7:0] HOLD_LAST = 8'(HOLD_MAX - 1);

    state_t     state, state_nxt;
    logic [1:0] ptr, ptr_nxt;
    logic [7:0] hold_cnt, hold_nxt;
    logic [3:0] gnt_nxt;
    logic [1:0] sel_nxt;
    logic       busy_nxt;
    logic [3:0] others;
    logic [1:0] winner_any, winner_others;

    // Search starts one past 'last', so 'last' itself is the final candidate.
    function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] last);
        logic [1:0] idx;
        logic       found;
        rr_pick = last;
        found   = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            idx = last + 2'(k);
            if (r[idx] && !found) begin
                rr_pick = idx;
                found   = 1'b1;
            end
        end
    endfunction

    assign others        = req & ~(4'b0001 << sel);
    assign winner_any    = rr_pick(req, ptr);
    assign winner_others = rr_pick(others, sel);

    always_comb begin
        state_nxt = state;
        gnt_nxt   = gnt;
        sel_nxt   = sel;
        busy_nxt  = busy;
        hold_nxt  = hold_cnt;
        ptr_nxt   = ptr;
        case (state)
            IDLE: begin
                if (|req) begin
                    state_nxt = BUSY;
                    gnt_nxt   = 4'b0001 << winner_any;
                    sel_nxt   = winner_any;
                    ptr_nxt   = winner_any;
                    busy_nxt  = 1'b1;
                    hold_nxt  = 8'd0;
                end
            end
            BUSY: begin
                if (!req[sel]) begin
                    if (|req) begin
                        gnt_nxt  = 4'b0001 << winner_any;
                        sel_nxt  = winner_any;
                        ptr_nxt  = winner_any;
                        hold_nxt = 8'd0;
                    end else begin
                        state_nxt = IDLE;
                        gnt_nxt   = 4'b0000;
                        sel_nxt   = 2'd0;
                        busy_nxt  = 1'b0;
                        hold_nxt  = 8'd0;
                    end
                end else if (hold_cnt < HOLD_LAST) begin
                    hold_nxt = hold_cnt + 8'd1;
                end else if (|others) begin
                    // Timeout with contenders: the owner is masked out so it ranks last.
                    gnt_nxt  = 4'b0001 << winner_others;
                    sel_nxt  = winner_others;
                    ptr_nxt  = winner_others;
                    hold_nxt = 8'd0;
                end else begin
                    hold_nxt = 8'd0;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Pointer resets to 3 so requester 0 is searched first.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            gnt      <= 4'b0000;
            sel      <= 2'd0;
            busy     <= 1'b0;
            hold_cnt <= 8'd0;
            ptr      <= 2'd3;
        end else begin
            state    <= state_nxt;
            gnt      <= gnt_nxt;
            sel      <= sel_nxt;
            busy     <= busy_nxt;
            hold_cnt <= hold_nxt;
            ptr      <= ptr_nxt;
        end
    end

    always_comb begin
        y = 1'b0;
        if (busy) begin
            case (sel)
                2'd0:    y = a;
                2'd1:    y = b;
                2'd2:    y = c;
                default: y = d;
            endcase
        end
    end

endmodule
